// File: rtl/cnn_dbg_pkg.sv
// Shared types and helpers for the CNN debug/readout blocks.
package cnn_dbg_pkg;

    typedef enum logic [1:0] {
        SCAN_IDLE,
        SCAN_RUN,
        SCAN_DONE
    } scan_state_t;

    // Index width that never collapses to zero bits for tiny channel counts.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chan_scan_serializer.sv
// Snapshots NUM_CH channel values on start and streams them out as (index, value) beats.
// Latency: first beat one cycle after the start edge; done pulses one cycle after the last beat.
// Backpressure: a presented beat holds stable until accepted; zero channels skip in one cycle when enabled.
module chan_scan_serializer
    import cnn_dbg_pkg::*;
#(
    parameter  int NUM_CH    = 4,
    parameter  int DATA_W    = 3,
    parameter  int SKIP_ZERO = 0,
    localparam int IDX_W     = clog2_min1(NUM_CH),
    localparam int CNT_W     = $clog2(NUM_CH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic                     start,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IDX_W-1:0]         out_idx,
    output logic [DATA_W-1:0]        out_data,
    output logic                     done,
    output logic [CNT_W-1:0]         out_count
);

    localparam logic             SKIP_EN  = (SKIP_ZERO != 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    scan_state_t       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  out_count_q, out_count_d;

    logic [DATA_W-1:0] snap [NUM_CH];
    logic [DATA_W-1:0] cur;
    logic              load;
    logic              run;
    logic              is_zero;
    logic              skip;
    logic              fire;
    logic              advance;

    assign load    = (state_q == SCAN_IDLE) && start;
    assign run     = (state_q == SCAN_RUN);
    assign cur     = snap[idx_q];
    assign is_zero = (cur == '0);
    assign skip    = run && SKIP_EN && is_zero;
    assign fire    = out_valid && out_ready;
    assign advance = fire || skip;

    // Shadow bank: frozen at capture so live channel data cannot disturb a scan.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_W-1:0] snap_q, snap_d;

        always_comb begin
            snap_d = snap_q;
            if (load) begin
                snap_d = ch_data[c*DATA_W +: DATA_W];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                snap_q <= '0;
            end else begin
                snap_q <= snap_d;
            end
        end

        assign snap[c] = snap_q;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        out_count_d = out_count_q;
        case (state_q)
            SCAN_IDLE: begin
                if (start) begin
                    state_d = SCAN_RUN;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            SCAN_RUN: begin
                if (fire) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // The index parks on the last channel rather than wrapping.
                if (advance) begin
                    if (idx_q == LAST_IDX) begin
                        state_d     = SCAN_DONE;
                        out_count_d = cnt_d;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            SCAN_DONE: begin
                state_d = SCAN_IDLE;
            end
            default: begin
                state_d = SCAN_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SCAN_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            out_count_q <= out_count_d;
        end
    end

    assign busy      = (state_q != SCAN_IDLE);
    assign out_valid = run && !(SKIP_EN && is_zero);
    assign out_idx   = run ? idx_q : '0;
    assign out_data  = run ? cur : '0;
    assign done      = (state_q == SCAN_DONE);
    assign out_count = out_count_q;

endmodule
